instr_fetch_queue: RTL and testbench

Instruction fetch stage feeding the control unit and register-file decode. Holds the program counter and issues word reads to instruction memory, one outstanding at a time. Buffers returned instructions in a small in-order queue and presents the head instruction to decode with split opcode and function-code fields. Jump redirects from decode flush the queue and restart fetch at the target.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/instr_fetch_queue.sv | 92 +++++++++
 tb/tb_instr_fetch_queue.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, opcode/function
// constants and the fetch state encoding used by fetch and decode.
package cpu_pkg;

  localparam int unsigned OPCODE_W    = 4;
  localparam int unsigned FUNC_W      = 4;

  localparam int unsigned OPCODE_MSB  = 15;
  localparam int unsigned OPCODE_LSB  = 12;
  localparam int unsigned RS_MSB      = 11;
  localparam int unsigned RS_LSB      = 8;
  localparam int unsigned RT_MSB      = 7;
  localparam int unsigned RT_LSB      = 4;
  localparam int unsigned FUNC_MSB    = 3;
  localparam int unsigned FUNC_LSB    = 0;
  localparam int unsigned IMM_MSB     = 3;
  localparam int unsigned IMM_LSB     = 0;
  localparam int unsigned JTARGET_MSB = 11;
  localparam int unsigned JTARGET_LSB = 0;

  localparam logic [OPCODE_W-1:0] OP_R_TYPE = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_LW     = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SW     = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_JMP    = 4'b0110;

  localparam logic [FUNC_W-1:0] FN_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] FN_SUB = 4'b0001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {pc, instr} entries; flush empties it in one cycle
// and takes priority over push/pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 24,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is reset too so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch: PC, single-outstanding imem request, and a small queue
// presenting the head instruction to decode; redirects flush and restart.
module instr_fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic [FUNC_W-1:0]   if_function_code,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_target
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic               enq, deq, flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Request is gated by registered count only, so a dequeue never bypasses into it.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    enq      = 1'b0;
    deq      = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        if (redirect) pc_d = redirect_target;
      end
      RUN: begin
        imem_req = (count < CNT_W'(DEPTH)) && !redirect;
        enq      = imem_req && imem_rvalid;
        deq      = if_valid && if_ready;
        flush    = redirect;
        if (redirect)  pc_d = redirect_target;
        else if (enq)  pc_d = pc_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (enq),
    .push_data ({pc_q, imem_rdata}),
    .pop       (deq),
    .head_data (head),
    .count     (count)
  );

  assign imem_addr        = pc_q;
  assign if_valid         = (count != '0);
  assign if_pc            = head[ENTRY_W-1:INSTR_W];
  assign if_instr         = head[INSTR_W-1:0];
  assign if_opcode        = if_instr[OPCODE_MSB:OPCODE_LSB];
  assign if_function_code = if_instr[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a scoreboard of expected {pc, instr}
// entries filled as responses are driven and drained as decode accepts them.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic [3:0]  if_opcode;
  logic [3:0]  if_function_code;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_target = '0;

  instr_fetch_queue #(
    .ADDR_W   (8),
    .INSTR_W  (16),
    .DEPTH    (DEPTH),
    .RESET_PC (0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .if_opcode        (if_opcode),
    .if_function_code (if_function_code),
    .redirect         (redirect),
    .redirect_target  (redirect_target)
  );

  always #5 clk = ~clk;

  logic [23:0] sb [$];
  logic [7:0]  m_pc = '0;
  bit          m_run = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, then advance the model.
  task automatic step(input logic rv, input logic [15:0] rd, input logic rdy,
                      input logic rdr, input logic [7:0] tgt);
    logic        exp_req;
    logic [23:0] e;
    @(negedge clk);
    imem_rvalid     = rv;
    imem_rdata      = rd;
    if_ready        = rdy;
    redirect        = rdr;
    redirect_target = tgt;
    #1;
    exp_req = m_run && (sb.size() < DEPTH) && !rdr;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("if_valid", 32'(if_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      e = sb[0];
      chk("if_pc", 32'(if_pc), 32'(e[23:16]));
      chk("if_instr", 32'(if_instr), 32'(e[15:0]));
      chk("if_opcode", 32'(if_opcode), 32'(e[15:12]));
      chk("if_function_code", 32'(if_function_code), 32'(e[3:0]));
      if (rdy) void'(sb.pop_front());
    end
    if (rdr) begin
      sb.delete();
      m_pc = tgt;
    end else if (exp_req && rv) begin
      sb.push_back({m_pc, rd});
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_pc"}, 32'(if_pc), 32'd0);
    chk({tag, "_if_instr"}, 32'(if_instr), 32'd0);
    chk({tag, "_if_opcode"}, 32'(if_opcode), 32'd0);
    chk({tag, "_if_function_code"}, 32'(if_function_code), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset_imem_addr", 32'(imem_addr), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_imem_req", 32'(imem_req), 32'd0);
    m_run = 1'b1;

    // First fetch, then fill with if_ready low until full
    step(1'b1, 16'h0010, 1'b0, 1'b0, 8'h00);
    step(1'b1, 16'h0011, 1'b0, 1'b0, 8'h00);
    step(1'b1, 16'h0099, 1'b0, 1'b0, 8'h00);
    step(1'b1, 16'h0099, 1'b0, 1'b0, 8'h00);
    chk("full_pc", 32'(imem_addr), 32'h2);
    // Drain in order; request resumes the cycle after the first dequeue
    step(1'b1, 16'h0012, 1'b1, 1'b0, 8'h00);
    step(1'b1, 16'h0012, 1'b1, 1'b0, 8'h00);

    // Streaming SUB then LW with zero-wait memory
    step(1'b1, 16'h0121, 1'b1, 1'b0, 8'h00);
    step(1'b1, 16'h1230, 1'b1, 1'b0, 8'h00);
    chk("sub_function_code", 32'(if_function_code), 32'h1);
    step(1'b1, 16'h6040, 1'b1, 1'b0, 8'h00);
    chk("lw_opcode", 32'(if_opcode), 32'h1);

    // JMP at head retires with redirect while a response returns
    step(1'b1, 16'hdead, 1'b1, 1'b1, 8'h40);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
    chk("redirect_addr", 32'(imem_addr), 32'h40);
    step(1'b1, 16'h0232, 1'b1, 1'b0, 8'h00);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
    chk("target_if_pc", 32'(if_pc), 32'h40);

    // PC wrap from FF to 00, redirect while empty
    step(1'b0, 16'h0000, 1'b1, 1'b1, 8'hff);
    step(1'b1, 16'h0a0a, 1'b1, 1'b0, 8'h00);
    step(1'b1, 16'h0b0b, 1'b1, 1'b0, 8'h00);
    chk("wrap_head_pc_ff", 32'(if_pc), 32'hff);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
    chk("wrap_head_pc_00", 32'(if_pc), 32'h00);

    // Async reset with one entry queued and a request outstanding
    step(1'b1, 16'h2345, 1'b0, 1'b0, 8'h00);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    m_pc  = '0;
    m_run = 1'b0;
    imem_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset_idle_req", 32'(imem_req), 32'd0);
    m_run = 1'b1;
    step(1'b1, 16'h0121, 1'b1, 1'b0, 8'h00);
    chk("restart_addr_seen", 32'(m_pc), 32'h1);
    step(1'b1, 16'h0000, 1'b1, 1'b0, 8'h00);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
